// File: rtl/boot_pkg.sv
// +--------------------------------------------------------------------------+
// | boot_pkg: shared types and constants for the UART boot loader.           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package boot_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    WRITE   = 3'd4,
    CSUM    = 3'd5
  } boot_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam int ERR_FRAME   = 0;
  localparam int ERR_CSUM    = 1;
  localparam int ERR_TIMEOUT = 2;

endpackage

`default_nettype wire

// File: rtl/uart_rx_core.sv
// +--------------------------------------------------------------------------+
// | uart_rx_core: 8N1 receiver with input synchronizer and false-start check.|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_rx_core
  import boot_pkg::*;
#(
  parameter int CLK_HZ = 27_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr
);

  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int HALF    = BIT_CYC / 2;
  localparam int CW      = $clog2(BIT_CYC);

  rx_state_t     state_q, state_d;
  logic          rx_s1, rx_s2, rx_s3;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] tgt;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tick;
  logic          fall;

  assign fall    = rx_s3 & ~rx_s2;
  assign rx_data = shift_q;

  always_comb begin
    tgt     = (state_q == RX_START) ? CW'(HALF - 1) : CW'(BIT_CYC - 1);
    tick    = (state_q != RX_IDLE) && (cnt_q == tgt);
    state_d = state_q;
    case (state_q)
      RX_IDLE:  if (fall) state_d = RX_START;
      // Line back high at mid-start means a glitch, not a frame.
      RX_START: if (tick) state_d = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (tick) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      cnt_q    <= (state_q == RX_IDLE || tick) ? '0 : cnt_q + 1'b1;
      if (state_q == RX_START) begin
        bit_q <= '0;
      end
      if (state_q == RX_DATA && tick) begin
        shift_q <= {rx_s2, shift_q[7:1]};
        bit_q   <= bit_q + 1'b1;
      end
      if (state_q == RX_STOP && tick) begin
        rx_valid <= rx_s2;
        rx_ferr  <= ~rx_s2;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_boot_loader.sv
// +--------------------------------------------------------------------------+
// | uart_boot_loader: receives a framed image over UART, writes it to BSRAM. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int CLK_HZ      = 27_000_000,
  parameter int BAUD        = 115_200,
  parameter int ADDR_W      = 11,
  parameter int TIMEOUT_CYC = 2_700_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              mem_ce,
  output logic              mem_wre,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_din,
  output logic              busy,
  output logic              done,
  output logic [7:0]        words_loaded,
  output logic [2:0]        err
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  boot_state_t   state_q, state_d;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ferr;
  logic [7:0]    len_q, cnt_q, hi_q, sum_q;
  logic [TW-1:0] idle_cnt;
  logic          sync_hit, abort_frame, timeout_hit, csum_ok;

  uart_rx_core #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx       (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr)
  );

  assign mem_ce  = 1'b1;
  assign mem_wre = (state_q == WRITE);
  assign busy    = (state_q != IDLE);

  assign sync_hit    = (state_q == IDLE) && rx_valid && (rx_data == SYNC_BYTE);
  assign abort_frame = (state_q != IDLE) && rx_ferr;
  // A byte arriving on the expiry cycle keeps the packet alive.
  assign timeout_hit = (state_q != IDLE) && !rx_valid && (idle_cnt == TW'(TIMEOUT_CYC - 1));
  assign csum_ok     = (rx_data == sum_q);

  always_comb begin
    state_d = state_q;
    if (abort_frame || timeout_hit) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (sync_hit) state_d = LEN;
        LEN:     if (rx_valid) state_d = (rx_data == 8'd0) ? CSUM : DATA_HI;
        DATA_HI: if (rx_valid) state_d = DATA_LO;
        DATA_LO: if (rx_valid) state_d = WRITE;
        WRITE:   state_d = (cnt_q == 8'd1) ? CSUM : DATA_HI;
        CSUM:    if (rx_valid) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr     <= '0;
      mem_din      <= '0;
      done         <= 1'b0;
      words_loaded <= '0;
      err          <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      hi_q         <= '0;
      sum_q        <= '0;
      idle_cnt     <= '0;
    end else begin
      done     <= 1'b0;
      idle_cnt <= (state_q == IDLE || rx_valid) ? '0 : idle_cnt + 1'b1;
      if (sync_hit) begin
        err      <= '0;
        mem_addr <= '0;
        sum_q    <= '0;
      end
      if (abort_frame) err[ERR_FRAME] <= 1'b1;
      if (timeout_hit) err[ERR_TIMEOUT] <= 1'b1;
      if (rx_valid) begin
        case (state_q)
          LEN: begin
            len_q <= rx_data;
            cnt_q <= rx_data;
            sum_q <= rx_data;
          end
          DATA_HI: begin
            hi_q  <= rx_data;
            sum_q <= sum_q + rx_data;
          end
          DATA_LO: begin
            mem_din <= {hi_q, rx_data};
            sum_q   <= sum_q + rx_data;
          end
          CSUM: begin
            if (csum_ok) begin
              done         <= 1'b1;
              words_loaded <= len_q;
            end else begin
              err[ERR_CSUM] <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (state_q == WRITE) begin
        mem_addr <= mem_addr + 1'b1;
        cnt_q    <= cnt_q - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
